// File: rtl/register_file_pkg.sv
// Shared constants for the register file and branch-condition logic.
// Condition encodings, flag bit positions and default widths.
package register_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    COND_EQ  = 3'b000,
    COND_NE  = 3'b001,
    COND_AL  = 3'b010,
    COND_NV  = 3'b011,
    COND_LT  = 3'b100,
    COND_GE  = 3'b101,
    COND_LTU = 3'b110,
    COND_GEU = 3'b111
  } cond_e;

endpackage

// File: rtl/register_file_cond_check.sv
// Branch-condition evaluator: Cond x {N,Z,C,V} -> condition true.
// Pure combinational; shared with the branch unit.
module cond_check
  import register_file_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b0;
    unique case (cond_e'(cond))
      COND_EQ:  cond_ex = z;
      COND_NE:  cond_ex = !z;
      COND_AL:  cond_ex = 1'b1;
      COND_NV:  cond_ex = 1'b0;
      COND_LT:  cond_ex = n ^ v;
      COND_GE:  cond_ex = !(n ^ v);
      COND_LTU: cond_ex = !c;
      COND_GEU: cond_ex = c;
      default:  cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file (x0 = 0) plus registered NZCV flags.
// REGFILE_BYPASS_EN enables write-through forwarding of WD3/ALUFlags.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              RegWrite,
  input  logic              FlagWrite,
  input  logic [3:0]        ALUFlags,
  input  logic [2:0]        Cond,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [3:0]        Flags,
  output logic              CondEx
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [3:0]        flags_q;
  logic [3:0]        eval_flags;
  logic              wr_en;

  assign wr_en = RegWrite && (A3 != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[A3] <= WD3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 4'b0000;
    end else if (FlagWrite) begin
      flags_q <= ALUFlags;
    end
  end

  assign Flags = flags_q;

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    RD1 = '0;
    unique case (1'b1)
      (A1 == '0):          RD1 = '0;
      (wr_en && A3 == A1): RD1 = WD3;
      default:             RD1 = regs[A1];
    endcase
  end

  always_comb begin
    RD2 = '0;
    unique case (1'b1)
      (A2 == '0):          RD2 = '0;
      (wr_en && A3 == A2): RD2 = WD3;
      default:             RD2 = regs[A2];
    endcase
  end

  assign eval_flags = FlagWrite ? ALUFlags : flags_q;
`else
  assign RD1 = (A1 == '0) ? '0 : regs[A1];
  assign RD2 = (A2 == '0) ? '0 : regs[A2];

  assign eval_flags = flags_q;
`endif

  cond_check u_cond_check (
    .cond    (Cond),
    .flags   (eval_flags),
    .cond_ex (CondEx)
  );

endmodule
